mem_port_arbiter: RTL

//  Shares one single-port unified memory between instruction fetch (IF) and data load/store (DM).

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter sharing one RAM between instruction fetch and data access.
// Tie resolution: fixed DM priority by default, round-robin when ARB_RR_EN is defined.
module mem_port_arbiter #(
  parameter int AW      = 7,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

  logic [1:0]    stateReg;
  logic [3:0]    cntReg;
  logic          ownerReg;  // 1 = DM owns the in-flight access
  logic          ifAckReg;
  logic          dmAckReg;
  logic [DW-1:0] ifRdataReg;
  logic [DW-1:0] dmRdataReg;
  logic          memWeReg;
  logic [3:0]    memBeReg;
  logic [AW-1:0] memAddrReg;
  logic [DW-1:0] memWdataReg;
  logic          grantDm;

`ifdef ARB_RR_EN
  logic lastDmReg;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    grantDm = dm_req & (~if_req | ~lastDmReg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lastDmReg <= 1'b1;
    end else if (stateReg == IDLE && (if_req || dm_req)) begin
      lastDmReg <= grantDm;
    end
  end
`else
  always_comb begin
    grantDm = dm_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= IDLE;
      cntReg      <= '0;
      ownerReg    <= 1'b0;
      ifAckReg    <= 1'b0;
      dmAckReg    <= 1'b0;
      ifRdataReg  <= '0;
      dmRdataReg  <= '0;
      memWeReg    <= 1'b0;
      memBeReg    <= '0;
      memAddrReg  <= '0;
      memWdataReg <= '0;
    end else begin
      ifAckReg <= 1'b0;
      dmAckReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (if_req || dm_req) begin
            ownerReg <= grantDm;
            if (grantDm) begin
              memWeReg    <= dm_we;
              memBeReg    <= dm_be;
              memAddrReg  <= dm_addr;
              memWdataReg <= dm_wdata;
            end else begin
              memWeReg    <= 1'b0;
              memBeReg    <= 4'hF;
              memAddrReg  <= if_addr;
              memWdataReg <= '0;
            end
            stateReg <= ISSUE;
          end
        end
        ISSUE: begin
          cntReg   <= LAT_CNT;
          stateReg <= WAIT;
        end
        WAIT: begin
          cntReg <= cntReg - 4'd1;
          // Read data is only valid on the edge where the count reaches one.
          if (cntReg == 4'd1) begin
            if (!memWeReg) begin
              if (ownerReg) begin
                dmRdataReg <= mem_rdata;
              end else begin
                ifRdataReg <= mem_rdata;
              end
            end
            ifAckReg <= ~ownerReg;
            dmAckReg <= ownerReg;
            stateReg <= RESP;
          end
        end
        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = (stateReg == ISSUE);
  assign mem_we    = memWeReg;
  assign mem_be    = memBeReg;
  assign mem_addr  = memAddrReg;
  assign mem_wdata = memWdataReg;
  assign if_ack    = ifAckReg;
  assign dm_ack    = dmAckReg;
  assign if_rdata  = ifRdataReg;
  assign dm_rdata  = dmRdataReg;
  assign stall     = (if_req & ~if_ack) | (dm_req & ~dm_ack);

endmodule
